vec_ldst_unit: RTL and testbench



---
 rtl/vec_mem_pkg.sv | 10 +
 rtl/vec_addr_gen.sv | 20 ++
 rtl/vec_ldst_unit.sv | 106 ++++++++++
 tb/tb_vec_ldst_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared state encoding, default geometry and index-width helper for the vector memory sequencer.
package vec_mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_e;
  localparam int LANES_DEF = 16;
  localparam int ELEM_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  function automatic int idx_w(input int lanes);
    return $clog2(lanes);
  endfunction
endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: address accumulator with load/step/hold; stepping wraps modulo 2^ADDR_W.
module vec_addr_gen import vec_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] inc,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb addr_d = load ? base : step ? addr_q + inc : addr_q;
  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else addr_q <= addr_d;
  end
  assign addr = addr_q;
endmodule

// File: rtl/vec_ldst_unit.sv
// vec_ldst_unit: per-element vector load/store burst sequencer on a shared memory port.
// Define STRIDE_EN to latch and use the stride port; otherwise bursts are contiguous.
module vec_ldst_unit import vec_mem_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                      Clk1,
  input  logic                      Reset,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [idx_w(LANES)-1:0]   count,
  input  logic [LANES*ELEM_W-1:0]   st_data,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*ELEM_W-1:0]   ld_data,
  output logic [ADDR_W-1:0]         Addr,
  output logic                      RD,
  output logic                      WR,
  output logic [ELEM_W-1:0]         dataOut,
  input  logic [ELEM_W-1:0]         DataIn,
  input  logic                      mem_ready
);
  localparam int IW = idx_w(LANES);
  state_e state_q, state_d;
  logic st_q, st_d, cap_q, cap_d, go, acc;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d, cap_idx_q, cap_idx_d;
  logic [ELEM_W-1:0] ld_q [LANES];
  logic [ELEM_W-1:0] ld_d [LANES];
  logic [ELEM_W-1:0] st_lane [LANES];
  logic [ADDR_W-1:0] inc;
  assign go = state_q == IDLE && start;
  assign acc = state_q == REQ && mem_ready;
`ifdef STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  always_comb stride_d = go ? stride : stride_q;
  always_ff @(posedge Clk1) begin
    if (Reset) stride_q <= '0;
    else stride_q <= stride_d;
  end
  assign inc = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign inc = ADDR_W'(1);
`endif
  vec_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk(Clk1), .rst(Reset), .load(go), .step(acc),
    .base(base_addr), .inc(inc), .addr(Addr)
  );
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign st_lane[i] = st_data[i*ELEM_W +: ELEM_W];
    assign ld_data[i*ELEM_W +: ELEM_W] = ld_q[i];
  end
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    cap_d = acc && !st_q;
    cap_idx_d = idx_q;
    ld_d = ld_q;
    if (cap_q) ld_d[cap_idx_q] = DataIn;
    if (go && !is_store) ld_d = '{default: '0};
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        st_d = is_store;
        cnt_d = count;
        idx_d = '0;
      end
      REQ: if (mem_ready) begin
        idx_d = idx_q + IW'(1);
        if (idx_q == cnt_q) state_d = st_q ? DONE : DRAIN;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= IDLE;
      st_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      cap_q <= 1'b0;
      cap_idx_q <= '0;
      ld_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cap_q <= cap_d;
      cap_idx_q <= cap_idx_d;
      ld_q <= ld_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign RD = state_q == REQ && !st_q;
  assign WR = state_q == REQ && st_q;
  assign dataOut = WR ? st_lane[idx_q] : '0;
endmodule

// File: tb/tb_vec_ldst_unit.sv
// tb_vec_ldst_unit: directed self-checking bench for vec_ldst_unit (default 16 x 16-bit geometry).
module tb_vec_ldst_unit;
  logic Clk1, Reset, start, is_store, busy, done, RD, WR, mem_ready;
  logic [15:0] base_addr, stride, Addr, dataOut, DataIn;
  logic [3:0] count;
  logic [255:0] st_data, ld_data, exp_v;
  int n_cmp, n_bad;

  vec_ldst_unit dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .count(count), .st_data(st_data),
    .busy(busy), .done(done), .ld_data(ld_data), .Addr(Addr), .RD(RD), .WR(WR),
    .dataOut(dataOut), .DataIn(DataIn), .mem_ready(mem_ready)
  );

  initial begin
    Clk1 = 0;
    forever #5 Clk1 = ~Clk1;
  end

  // memory model: read data returns one cycle after an accepted read
  initial DataIn = '0;
  always @(posedge Clk1) if (RD && mem_ready) DataIn <= Addr ^ 16'hA5A5;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge Clk1);
  endtask

  task automatic kick(input logic s, input logic [15:0] b, input logic [15:0] str, input logic [3:0] c);
    @(negedge Clk1);
    start = 1; is_store = s; base_addr = b; stride = str; count = c;
    @(negedge Clk1);
    start = 0;
  endtask

  task automatic test_reset;
    Reset = 1;
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if ({RD, WR} !== 2'b00) begin n_bad++; $display("FAIL reset_rdwr: got %b want 00", {RD, WR}); end
    n_cmp++; if (Addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", Addr); end
    n_cmp++; if (dataOut !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", dataOut); end
    n_cmp++; if (ld_data !== '0) begin n_bad++; $display("FAIL reset_ld: got %h want 0", ld_data); end
    Reset = 0;
  endtask

  task automatic test_contig_load;
    mem_ready = 1;
    kick(0, 16'h0100, 16'h0001, 4'd15);
    for (int k = 1; k <= 18; k++) begin
      n_cmp++; if ({RD, WR} !== {k <= 16, 1'b0}) begin n_bad++; $display("FAIL cl_rdwr k=%0d: got %b want %b", k, {RD, WR}, {k <= 16, 1'b0}); end
      if (k <= 16) begin
        n_cmp++; if (Addr !== 16'h0100 + 16'(k - 1)) begin n_bad++; $display("FAIL cl_addr k=%0d: got %h want %h", k, Addr, 16'h0100 + 16'(k - 1)); end
      end
      n_cmp++; if (done !== (k == 18)) begin n_bad++; $display("FAIL cl_done k=%0d: got %b want %b", k, done, k == 18); end
      if (k < 18) tick();
    end
    for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = (16'h0100 + 16'(i)) ^ 16'hA5A5;
    n_cmp++; if (ld_data !== exp_v) begin n_bad++; $display("FAIL cl_data: got %h want %h", ld_data, exp_v); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cl_busy_done: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cl_idle: got %b want 0", busy); end
  endtask

  task automatic test_store_waits;
    int idx, n_done, n_acc;
    logic exp_done, exp_wr;
    idx = 0; n_done = 0; n_acc = 0; exp_done = 0;
    for (int i = 0; i < 16; i++) st_data[i*16 +: 16] = 16'hC000 + 16'(i) * 16'h0111;
    mem_ready = 1;
    kick(1, 16'h2000, 16'h0001, 4'd3);
    for (int k = 0; k < 12; k++) begin
      exp_wr = idx <= 3;
      n_cmp++; if ({RD, WR} !== {1'b0, exp_wr}) begin n_bad++; $display("FAIL sw_rdwr k=%0d: got %b want %b", k, {RD, WR}, {1'b0, exp_wr}); end
      if (exp_wr) begin
        n_cmp++; if (Addr !== 16'h2000 + 16'(idx)) begin n_bad++; $display("FAIL sw_addr k=%0d: got %h want %h", k, Addr, 16'h2000 + 16'(idx)); end
        n_cmp++; if (dataOut !== 16'hC000 + 16'(idx) * 16'h0111) begin n_bad++; $display("FAIL sw_dout k=%0d: got %h want %h", k, dataOut, 16'hC000 + 16'(idx) * 16'h0111); end
      end
      n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL sw_done k=%0d: got %b want %b", k, done, exp_done); end
      if (done) n_done++;
      mem_ready = (k % 2 == 1);
      exp_done = 0;
      if (exp_wr && mem_ready) begin
        idx++; n_acc++;
        if (idx == 4) exp_done = 1;
      end
      tick();
    end
    mem_ready = 1;
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL sw_ndone: got %0d want 1", n_done); end
  endtask

  task automatic test_stride;
    logic [15:0] ea [3];
`ifdef STRIDE_EN
    ea[0] = 16'hFFFE; ea[1] = 16'h0001; ea[2] = 16'h0004;
`else
    ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000;
`endif
    mem_ready = 1;
    kick(0, 16'hFFFE, 16'd3, 4'd2);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({RD, Addr} !== {1'b1, ea[k]}) begin n_bad++; $display("FAIL st_addr k=%0d: got %b/%h want 1/%h", k, RD, Addr, ea[k]); end
      tick();
    end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL st_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_short_load;
    mem_ready = 1;
    kick(0, 16'h0300, 16'h0001, 4'd0);
    n_cmp++; if ({RD, Addr, done} !== {1'b1, 16'h0300, 1'b0}) begin n_bad++; $display("FAIL sl_req: got %b/%h/%b want 1/0300/0", RD, Addr, done); end
    tick();
    n_cmp++; if ({RD, done} !== 2'b00) begin n_bad++; $display("FAIL sl_drain: got %b want 00", {RD, done}); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sl_done: got %b want 1", done); end
    exp_v = '0;
    exp_v[15:0] = 16'h0300 ^ 16'hA5A5;
    n_cmp++; if (ld_data !== exp_v) begin n_bad++; $display("FAIL sl_data: got %h want %h", ld_data, exp_v); end
    tick();
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    mem_ready = 1;
    kick(0, 16'h0400, 16'h0001, 4'd15);
    repeat (4) tick();
    n_cmp++; if (RD !== 1'b1) begin n_bad++; $display("FAIL rm_rd5: got %b want 1", RD); end
    Reset = 1;
    tick();
    Reset = 0;
    n_cmp++; if ({RD, busy, done} !== 3'b000) begin n_bad++; $display("FAIL rm_ctl: got %b want 000", {RD, busy, done}); end
    n_cmp++; if (ld_data !== '0) begin n_bad++; $display("FAIL rm_ld: got %h want 0", ld_data); end
    for (int k = 0; k < 20; k++) begin
      if (done) n_done++;
      tick();
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rm_nodone: got %0d want 0", n_done); end
    kick(0, 16'h0500, 16'h0001, 4'd1);
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (done !== (k == 4)) begin n_bad++; $display("FAIL rm_done k=%0d: got %b want %b", k, done, k == 4); end
      if (k < 4) tick();
    end
    exp_v = '0;
    exp_v[15:0] = 16'h0500 ^ 16'hA5A5;
    exp_v[31:16] = 16'h0501 ^ 16'hA5A5;
    n_cmp++; if (ld_data !== exp_v) begin n_bad++; $display("FAIL rm_data: got %h want %h", ld_data, exp_v); end
    tick();
  endtask

  task automatic test_start_busy;
    int n_done;
    n_done = 0;
    mem_ready = 1;
    kick(0, 16'h0600, 16'h0001, 4'd3);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++; if ({RD, WR} !== {k <= 4, 1'b0}) begin n_bad++; $display("FAIL sb_rdwr k=%0d: got %b want %b", k, {RD, WR}, {k <= 4, 1'b0}); end
      if (k <= 4) begin
        n_cmp++; if (Addr !== 16'h0600 + 16'(k - 1)) begin n_bad++; $display("FAIL sb_addr k=%0d: got %h want %h", k, Addr, 16'h0600 + 16'(k - 1)); end
      end
      n_cmp++; if (done !== (k == 6)) begin n_bad++; $display("FAIL sb_done k=%0d: got %b want %b", k, done, k == 6); end
      if (k == 6) begin
        exp_v = '0;
        for (int i = 0; i < 4; i++) exp_v[i*16 +: 16] = (16'h0600 + 16'(i)) ^ 16'hA5A5;
        n_cmp++; if (ld_data !== exp_v) begin n_bad++; $display("FAIL sb_data: got %h want %h", ld_data, exp_v); end
      end
      if (done) n_done++;
      if (k == 2) begin start = 1; is_store = 1; base_addr = 16'h0700; count = 4'd1; end
      if (k == 3) begin start = 0; is_store = 0; end
      tick();
    end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL sb_ndone: got %0d want 1", n_done); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    Reset = 1; start = 0; is_store = 0; base_addr = '0; stride = '0; count = '0;
    st_data = '0; mem_ready = 0; exp_v = '0;
    test_reset();
    test_contig_load();
    test_store_waits();
    test_stride();
    test_short_load();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
